// File: rtl/frame_receiver.sv
// rtl/frame_receiver.sv - 8N1 UART receiver with 0xFF / payload / 0xFE frame parser
//
// Receives bytes from the result transmitter and assembles NUM_OF_TAPS-byte
// frames delimited by a 0xFF header and a 0xFE trailer.
//
// Optional feature macro: FRAME_TIMEOUT_EN
//   defined   : an inter-byte timeout of TIMEOUT_BITS bit times aborts a frame
//               that stalls in PAYLOAD/TRAILER (frame_err pulse, back to HUNT).
//   undefined : no timeout; the parser waits indefinitely for the next byte.
//
// Ports:
//   clk        in   system clock, rising edge
//   res        in   asynchronous active-low reset
//   RX         in   serial line, idle high, LSB first
//   taps       out  last good payload, byte k (1-based) at [k*8-1 -: 8]
//   taps_valid out  one-cycle pulse when taps updates
//   frame_err  out  one-cycle pulse on a stop-bit, trailer or timeout error
//   byte_out   out  last correctly framed byte
//   byte_stb   out  one-cycle pulse when byte_out updates
//   busy       out  parser is outside HUNT

module frame_receiver #(
    parameter int NUM_OF_TAPS  = 5,
    parameter int CLKS_PER_BIT = 434,
    parameter int TIMEOUT_BITS = 20
) (
    input  logic                     clk,
    input  logic                     res,
    input  logic                     RX,
    output logic [NUM_OF_TAPS*8-1:0] taps,
    output logic                     taps_valid,
    output logic                     frame_err,
    output logic [7:0]               byte_out,
    output logic                     byte_stb,
    output logic                     busy
);

    localparam int TW             = NUM_OF_TAPS * 8;
    localparam int CW             = $clog2(CLKS_PER_BIT);
    localparam int PW             = $clog2(NUM_OF_TAPS + 1);
    localparam int TIMEOUT_CYCLES = TIMEOUT_BITS * CLKS_PER_BIT;

    localparam logic [CW-1:0] HALF_CNT  = CW'(CLKS_PER_BIT / 2);
    localparam logic [CW-1:0] LAST_CNT  = CW'(CLKS_PER_BIT - 1);
    localparam logic [PW-1:0] LAST_BYTE = PW'(NUM_OF_TAPS - 1);

    if (CLKS_PER_BIT < 4 || NUM_OF_TAPS < 1 || TIMEOUT_CYCLES < 1) begin : g_bad_params
        $error("frame_receiver: unsupported parameter values");
    end

    // ------------------------------------------------------------------
    // RX synchroniser plus one extra stage for falling-edge detection.
    // All three preset high so reset release never looks like a start edge.
    // ------------------------------------------------------------------
    logic rx_meta, rx_sync, rx_prev;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= RX;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    logic start_edge;
    assign start_edge = rx_prev & ~rx_sync;

    // ------------------------------------------------------------------
    // Bit engine
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {B_IDLE, B_START, B_DATA, B_STOP} bit_state_t;

    bit_state_t    bstate, bstate_nxt;
    logic [CW-1:0] clk_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shreg;
    logic          clk_cnt_clr, data_sample, stop_good, stop_bad;

    always_ff @(posedge clk or negedge res) begin
        if (!res) bstate <= B_IDLE;
        else      bstate <= bstate_nxt;
    end

    always_comb begin
        bstate_nxt = bstate;
        case (bstate)
            B_IDLE:  if (start_edge) bstate_nxt = B_START;
            B_START: if (clk_cnt == HALF_CNT) bstate_nxt = rx_sync ? B_IDLE : B_DATA;
            B_DATA:  if (clk_cnt == LAST_CNT && bit_idx == 3'd7) bstate_nxt = B_STOP;
            B_STOP:  if (clk_cnt == LAST_CNT) bstate_nxt = B_IDLE;
            default: bstate_nxt = B_IDLE;
        endcase
    end

    // The counter restarts at every sample point, so each later sample
    // lands CLKS_PER_BIT cycles after the previous one.
    always_comb begin
        clk_cnt_clr = 1'b0;
        data_sample = 1'b0;
        stop_good   = 1'b0;
        stop_bad    = 1'b0;
        case (bstate)
            B_IDLE:  clk_cnt_clr = 1'b1;
            B_START: clk_cnt_clr = (clk_cnt == HALF_CNT);
            B_DATA: begin
                data_sample = (clk_cnt == LAST_CNT);
                clk_cnt_clr = data_sample;
            end
            B_STOP: begin
                clk_cnt_clr = (clk_cnt == LAST_CNT);
                stop_good   = (clk_cnt == LAST_CNT) &&  rx_sync;
                stop_bad    = (clk_cnt == LAST_CNT) && !rx_sync;
            end
            default: clk_cnt_clr = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            clk_cnt  <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            byte_out <= '0;
            byte_stb <= 1'b0;
        end else begin
            clk_cnt <= clk_cnt_clr ? '0 : clk_cnt + 1'b1;
            // bit_idx wraps 7 -> 0 on the eighth sample, ready for the next byte
            if (data_sample) begin
                bit_idx <= bit_idx + 1'b1;
                shreg   <= {rx_sync, shreg[7:1]};
            end
            byte_stb <= stop_good;
            if (stop_good) byte_out <= shreg;
        end
    end

    // ------------------------------------------------------------------
    // Frame parser
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {P_HUNT, P_PAYLOAD, P_TRAILER} parse_state_t;

    parse_state_t  pstate, pstate_nxt;
    logic [PW-1:0] pay_cnt;
    logic [TW-1:0] shadow;
    logic          timeout_hit, abort;
    logic          store_byte, deliver, trailer_err;

    // A framing error or timeout overrides whatever the parser was doing.
    assign abort = stop_bad | timeout_hit;
    assign busy  = (pstate != P_HUNT);

    always_ff @(posedge clk or negedge res) begin
        if (!res) pstate <= P_HUNT;
        else      pstate <= pstate_nxt;
    end

    always_comb begin
        pstate_nxt = pstate;
        if (abort) begin
            pstate_nxt = P_HUNT;
        end else if (byte_stb) begin
            case (pstate)
                P_HUNT:    if (byte_out == 8'hFF) pstate_nxt = P_PAYLOAD;
                P_PAYLOAD: if (pay_cnt == LAST_BYTE) pstate_nxt = P_TRAILER;
                // A stray 0xFF in the trailer slot is treated as a new header.
                P_TRAILER: pstate_nxt = (byte_out == 8'hFF) ? P_PAYLOAD : P_HUNT;
                default:   pstate_nxt = P_HUNT;
            endcase
        end
    end

    always_comb begin
        store_byte  = 1'b0;
        deliver     = 1'b0;
        trailer_err = 1'b0;
        if (!abort && byte_stb) begin
            case (pstate)
                P_PAYLOAD: store_byte = 1'b1;
                P_TRAILER: begin
                    deliver     = (byte_out == 8'hFE);
                    trailer_err = (byte_out != 8'hFE);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pay_cnt    <= '0;
            shadow     <= '0;
            taps       <= '0;
            taps_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            // Count only while collecting payload; every entry to PAYLOAD starts at 0.
            if (pstate_nxt != P_PAYLOAD) pay_cnt <= '0;
            else if (store_byte)         pay_cnt <= pay_cnt + 1'b1;
            if (store_byte) shadow[int'(pay_cnt)*8 +: 8] <= byte_out;
            if (deliver)    taps <= shadow;
            taps_valid <= deliver;
            frame_err  <= stop_bad | trailer_err | timeout_hit;
        end
    end

`ifdef FRAME_TIMEOUT_EN
    localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);

    logic [TOW-1:0] to_cnt;

    // Counts idle line time while a frame is open; a start edge restarts it.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            to_cnt <= '0;
        end else if (!busy || timeout_hit || (bstate == B_IDLE && start_edge)) begin
            to_cnt <= '0;
        end else if (bstate == B_IDLE) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // byte_stb masks the hit so a trailer result and a timeout never collide.
    assign timeout_hit = busy && (bstate == B_IDLE) && !start_edge && !byte_stb &&
                         (to_cnt == TOW'(TIMEOUT_CYCLES));
`else
    assign timeout_hit = 1'b0;
`endif

endmodule

// File: tb/tb_frame_receiver.sv
// tb/tb_frame_receiver.sv - scoreboard bench for frame_receiver
`timescale 1ns/1ps

module tb_frame_receiver;

    localparam int N   = 5;
    localparam int CPB = 16;
    localparam int TOB = 20;
    localparam int TW  = N * 8;

    logic          clk = 1'b0;
    logic          res;
    logic          rx;
    logic [TW-1:0] taps;
    logic          taps_valid;
    logic          frame_err;
    logic [7:0]    byte_out;
    logic          byte_stb;
    logic          busy;

    always #5 clk = ~clk;

    frame_receiver #(
        .NUM_OF_TAPS (N),
        .CLKS_PER_BIT(CPB),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clk       (clk),
        .res       (res),
        .RX        (rx),
        .taps      (taps),
        .taps_valid(taps_valid),
        .frame_err (frame_err),
        .byte_out  (byte_out),
        .byte_stb  (byte_stb),
        .busy      (busy)
    );

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        bit            is_err;
        logic [TW-1:0] val;
    } ev_t;

    ev_t        exp_ev[$];
    logic [7:0] exp_bytes[$];
    logic [TW-1:0] exp_taps;

    // Reference model: 0 = waiting for header, 1 = collecting, 2 = expecting trailer
    int         m_mode = 0;
    logic [7:0] m_pay[$];

    function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endfunction

    function automatic void model_byte(input logic [7:0] b);
        ev_t e;
        exp_bytes.push_back(b);
        case (m_mode)
            0: if (b == 8'hFF) begin
                m_mode = 1;
                m_pay.delete();
            end
            1: begin
                m_pay.push_back(b);
                if (m_pay.size() == N) m_mode = 2;
            end
            default: begin
                e.val = '0;
                if (b == 8'hFE) begin
                    e.is_err = 1'b0;
                    foreach (m_pay[k]) e.val[k*8 +: 8] = m_pay[k];
                    m_mode = 0;
                end else begin
                    e.is_err = 1'b1;
                    m_mode   = (b == 8'hFF) ? 1 : 0;
                end
                m_pay.delete();
                exp_ev.push_back(e);
            end
        endcase
    endfunction

    function automatic void model_error();
        ev_t e;
        e.is_err = 1'b1;
        e.val    = '0;
        exp_ev.push_back(e);
        m_mode = 0;
        m_pay.delete();
    endfunction

    // Monitor: pops expectations whenever the DUT presents a pulse.
    ev_t mon_e;
    always @(negedge clk) begin
        if (!res) begin
            exp_taps = '0;
        end else begin
            if (byte_stb) begin
                if (exp_bytes.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL byte_stb: got byte %0h expected no byte", byte_out);
                end else begin
                    check("byte_out", 64'(byte_out), 64'(exp_bytes.pop_front()));
                end
            end
            if (taps_valid || frame_err) begin
                check("pulse_overlap", 64'(taps_valid & frame_err), 64'(0));
                if (exp_ev.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL event: got taps_valid=%0b frame_err=%0b expected no event",
                             taps_valid, frame_err);
                end else begin
                    mon_e = exp_ev.pop_front();
                    check("event_kind", 64'(frame_err), 64'(mon_e.is_err));
                    if (!mon_e.is_err) exp_taps = mon_e.val;
                end
            end
            check("taps_value", 64'(taps), 64'(exp_taps));
        end
    end

    task automatic drive_bit(input logic v);
        @(posedge clk);
        #1 rx = v;
        repeat (CPB - 1) @(posedge clk);
    endtask

    task automatic idle_cycles(input int n);
        repeat (n) @(posedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_ok);
        if (stop_ok) model_byte(b);
        else         model_error();
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(b[i]);
        drive_bit(stop_ok);
        if (!stop_ok) drive_bit(1'b1);
    endtask

    // Sends n bytes from v, most significant byte first, with no gaps.
    task automatic send_packed(input logic [127:0] v, input int n);
        for (int i = n - 1; i >= 0; i--) send_byte(v[i*8 +: 8], 1'b1);
    endtask

    task automatic glitch();
        @(posedge clk);
        #1 rx = 1'b0;
        repeat (3) @(posedge clk);
        #1 rx = 1'b1;
    endtask

    task automatic drain_check(input string name);
        check({name, "_events_left"}, 64'(exp_ev.size()), 64'(0));
        check({name, "_bytes_left"}, 64'(exp_bytes.size()), 64'(0));
    endtask

    initial begin
        res = 1'b0;
        rx  = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_taps", 64'(taps), 64'(0));
        check("reset_taps_valid", 64'(taps_valid), 64'(0));
        check("reset_frame_err", 64'(frame_err), 64'(0));
        check("reset_byte_out", 64'(byte_out), 64'(0));
        check("reset_byte_stb", 64'(byte_stb), 64'(0));
        check("reset_busy", 64'(busy), 64'(0));
        res = 1'b1;
        idle_cycles(2 * CPB);

        // Basic frame
        send_packed(128'hFF1122334455FE, 7);
        idle_cycles(2 * CPB);
        check("t1_taps", 64'(taps), 64'h5544332211);
        check("t1_busy", 64'(busy), 64'(0));
        drain_check("t1");

        // FF/FE inside payload are data
        send_packed(128'hFFFFFE0001FEFE, 7);
        idle_cycles(2 * CPB);
        check("t2_taps", 64'(taps), 64'hFE0100FEFF);
        drain_check("t2");

        // Bad trailer, then bad trailer followed by resync frame
        send_packed(128'hFF0102030405AA, 7);
        idle_cycles(CPB);
        check("t3_taps_kept", 64'(taps), 64'hFE0100FEFF);
        check("t3_busy", 64'(busy), 64'(0));
        send_packed(128'hFF010203040577FF0A0B0C0D0EFE, 14);
        idle_cycles(2 * CPB);
        check("t3_taps", 64'(taps), 64'h0E0D0C0B0A);
        drain_check("t3");

        // Stop bit low mid-payload
        send_packed(128'hFF0102, 3);
        send_byte(8'h03, 1'b0);
        check("t4_busy_after_err", 64'(busy), 64'(0));
        send_packed(128'h0405FE, 3);
        send_packed(128'hFF2122232425FE, 7);
        idle_cycles(2 * CPB);
        check("t4_taps", 64'(taps), 64'h2524232221);
        drain_check("t4");

        // Short glitch while idle
        glitch();
        idle_cycles(3 * CPB);
        drain_check("t5_glitch");

        // Stalled frame: timeout with the macro, indefinite wait without
        send_packed(128'hFF0102, 3);
`ifdef FRAME_TIMEOUT_EN
        model_error();
        idle_cycles((TOB + 2) * CPB);
        check("t6_busy", 64'(busy), 64'(0));
        send_packed(128'h030405FE, 4);
        idle_cycles(2 * CPB);
        check("t6_taps", 64'(taps), 64'h2524232221);
`else
        idle_cycles((TOB + 2) * CPB);
        check("t6_busy", 64'(busy), 64'(1));
        send_packed(128'h030405FE, 4);
        idle_cycles(2 * CPB);
        check("t6_taps", 64'(taps), 64'h0504030201);
`endif
        drain_check("t6");

        // Reset in the middle of a payload byte
        send_packed(128'hFF0102, 3);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        @(posedge clk);
        #1 res = 1'b0;
        rx = 1'b1;
        #2;
        check("mid_reset_taps", 64'(taps), 64'(0));
        check("mid_reset_busy", 64'(busy), 64'(0));
        check("mid_reset_byte_out", 64'(byte_out), 64'(0));
        drain_check("mid_reset");
        m_mode = 0;
        m_pay.delete();
        repeat (3) @(posedge clk);
        #1 res = 1'b1;
        idle_cycles(2 * CPB);
        send_packed(128'h0304FE, 3);
        send_packed(128'hFFA1A2A3A4A5FE, 7);
        idle_cycles(2 * CPB);
        check("post_reset_taps", 64'(taps), 64'hA5A4A3A2A1);
        drain_check("post_reset");

        // Randomised traffic against the reference model
        for (int it = 0; it < 40; it++) begin
            int kind;
            kind = $urandom_range(0, 2);
            if (kind == 0) begin
                send_byte(8'hFF, 1'b1);
                for (int k = 0; k < N; k++) send_byte(8'($urandom), 1'b1);
                send_byte(($urandom_range(0, 4) == 0) ? 8'($urandom) : 8'hFE, 1'b1);
            end else if (kind == 1) begin
                int nb;
                nb = $urandom_range(1, 6);
                for (int k = 0; k < nb; k++) begin
                    int r;
                    logic [7:0] b;
                    r = $urandom_range(0, 99);
                    b = (r < 20) ? 8'hFF : (r < 35) ? 8'hFE : 8'($urandom);
                    send_byte(b, ($urandom_range(0, 14) != 0));
                end
            end else begin
                idle_cycles(CPB);
                glitch();
                idle_cycles(2 * CPB);
            end
            idle_cycles($urandom_range(0, 2 * CPB));
        end

        idle_cycles(3 * CPB);
        drain_check("final");
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
